// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the Wishbone configuration loader.
//   - CFG_BASE_ADDR : base of the configurator register window
//   - CFG_TIMEOUT   : default number of strobe cycles allowed before an ack
//   - HDR_*         : header word field positions and widths
//   - cfg_state_e   : loader FSM states
//   - hdr_word_addr : turns a header offset into a word-aligned bus address
package fpga_cfg_pkg;

  localparam logic [31:0] CFG_BASE_ADDR = 32'h3000_0000;
  localparam int          CFG_TIMEOUT   = 255;

  // Header word: [31] INC, [30:16] COUNT, [15:0] byte OFFSET.
  localparam int HDR_INC_BIT = 31;
  localparam int HDR_CNT_LSB = 16;
  localparam int HDR_CNT_W   = 15;
  localparam int HDR_OFS_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    ERR  = 2'd3
  } cfg_state_e;

  // Offset bits [1:0] are dropped so every access is word aligned.
  function automatic logic [31:0] hdr_word_addr(input logic [31:0]          base,
                                                input logic [HDR_OFS_W-1:0] ofs);
    logic [HDR_OFS_W-1:0] aligned;
    aligned = ofs & {{(HDR_OFS_W-2){1'b1}}, 2'b00};
    return base + 32'(aligned);
  endfunction

endpackage

// File: rtl/wb_config_loader_if.sv
// Wishbone write-only bus between the loader (master) and the configurator (slave).
//   cyc, stb : cycle / strobe
//   we       : write enable
//   sel      : byte select
//   adr      : byte address
//   dat      : write data
//   ack      : responder acknowledge
interface wb_config_loader_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat, input ack);
  modport slave  (input cyc, stb, we, sel, adr, dat, output ack);
endinterface

// File: rtl/wb_timeout_counter.sv
// Counts strobe cycles of one Wishbone request and flags when TIMEOUT cycles
// have elapsed without the request being retired.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : hold the count at zero (used while no request is pending)
//   en_i       : a request cycle is in progress
//   expired_o  : high during the TIMEOUT-th request cycle
module wb_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q, count_d;

  // The count equals the number of request cycles already completed, so the
  // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
  assign expired_o = en_i && (count_q == W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_config_loader.sv
// Wishbone initiator feeding the FPGA configuration port. A header word
// selects address, word count and address-increment mode; the following data
// words are written one at a time as single Wishbone write cycles.
//   wb_clk_i, wb_rst_i     : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  : stream handshake, in_data_i header or data word
//   abort_i                : drop the current burst and return to IDLE
//   clear_i                : leave the error state, clearing err_o
//   wbm                    : Wishbone master port
//   busy_o                 : FSM not in IDLE
//   done_o                 : one-cycle pulse after a burst completes
//   err_o                  : sticky ack-timeout error
//   words_o                : number of acked writes since reset (wrapping)
module wb_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CFG_BASE_ADDR,
  parameter int          CNT_W     = HDR_CNT_W,
  parameter int          TIMEOUT   = CFG_TIMEOUT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_data_i,
  input  logic               abort_i,
  input  logic               clear_i,
  wb_config_loader_if.master wbm,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [15:0]        words_o
);

  cfg_state_e        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              req_q, req_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       words_q, words_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              inc_q, inc_d;

  logic              accept;
  logic              in_req;
  logic              ack_hit;
  logic              expired;
  logic [CNT_W-1:0]  hdr_count;

  assign accept    = in_valid_i && in_ready_q;
  assign in_req    = (state_q == REQ);
  assign ack_hit   = in_req && wbm.ack;
  assign hdr_count = in_data_i[HDR_CNT_LSB +: CNT_W];

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_i),
    .clear_i   (!in_req),
    .en_i      (in_req),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    err_d   = err_q;
    words_d = words_q;
    rem_d   = rem_q;
    inc_d   = inc_q;

    // Any ack taken in REQ is counted, even one that coincides with abort.
    if (ack_hit) begin
      words_d = words_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rem_d = hdr_count;
          inc_d = in_data_i[HDR_INC_BIT];
          adr_d = hdr_word_addr(BASE_ADDR, in_data_i[HDR_OFS_W-1:0]);
          if (hdr_count != '0) begin
            state_d = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          dat_d   = in_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack beats a timeout expiring in the same cycle.
        if (ack_hit) begin
          rem_d = rem_q - 1'b1;
          if (inc_q) begin
            adr_d = adr_q + 32'd4;
          end
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (expired) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      ERR: begin
        if (clear_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins everywhere except ERR; a word handshaken in the same cycle
    // is consumed and discarded.
    if (abort_i && (state_q != ERR)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    // Bus and stream outputs are registered images of the next state.
    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    req_d      = (state_d == REQ);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      req_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      rem_q      <= '0;
      inc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      req_q      <= req_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      rem_q      <= rem_d;
      inc_q      <= inc_d;
    end
  end

  assign wbm.cyc = req_q;
  assign wbm.stb = req_q;
  assign wbm.we  = req_q;
  assign wbm.sel = {4{req_q}};
  assign wbm.adr = adr_q;
  assign wbm.dat = dat_q;

  assign in_ready_o = in_ready_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign words_o    = words_q;

endmodule

// File: tb/tb_wb_config_loader.sv
module tb_wb_config_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready_o;
  logic [31:0] in_data;
  logic        abort;
  logic        clear;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [15:0] words_o;

  wb_config_loader_if wb ();

  wb_config_loader #(
    .TIMEOUT (4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data),
    .abort_i    (abort),
    .clear_i    (clear),
    .wbm        (wb),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .words_o    (words_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          ack_dly = 1;
  bit          ack_en = 1'b1;
  wr_t         obs_q[$];
  logic [15:0] exp_words = 16'd0;

  always @(negedge clk) begin
    if (done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Wishbone responder: acks after ack_dly extra strobe cycles, logging each write.
  initial begin
    int k;
    wr_t w;
    k = 0;
    wb.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb.ack === 1'b1) begin
        wb.ack = 1'b0;
        k = 0;
      end else if (ack_en && wb.cyc === 1'b1 && wb.stb === 1'b1) begin
        if (k == ack_dly) begin
          w.adr = wb.adr;
          w.dat = wb.dat;
          w.sel = wb.sel;
          w.we  = wb.we;
          obs_q.push_back(w);
          wb.ack = 1'b1;
        end else begin
          k++;
        end
      end else begin
        k = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] d);
    bit took;
    int n;
    took = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!took && n < 200) begin
      took = (in_ready_o === 1'b1);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("handshake", 32'(took), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle"}, 32'(busy_o), 32'd0);
  endtask

  // Reference: COUNT writes starting at BASE + aligned OFFSET, stepping by 4 when INC.
  task automatic run_burst(input string tag, input logic [31:0] hdr, input int dly, input bit pattern);
    int          cnt;
    int          done0;
    logic [31:0] base_a;
    logic [31:0] d;
    wr_t         e;
    wr_t         exp_q[$];
    cnt    = int'((hdr >> 16) & 32'h0000_7FFF);
    base_a = BASE + (hdr & 32'h0000_FFFC);
    ack_dly = dly;
    ack_en  = 1'b1;
    obs_q.delete();
    done0 = done_cnt;
    send_word(hdr);
    if (cnt == 0) begin
      chk({tag, " done_pulse"}, 32'(done_o), 32'd1);
      chk({tag, " ready_kept"}, 32'(in_ready_o), 32'd1);
      chk({tag, " no_cyc"}, 32'(wb.cyc), 32'd0);
      @(negedge clk);
      chk({tag, " done_1cyc"}, 32'(done_o), 32'd0);
    end
    for (int i = 0; i < cnt; i++) begin
      d = pattern ? (32'hA5A5_0001 + 32'(i)) : $urandom;
      e.adr = base_a + (hdr[31] ? 32'(4 * i) : 32'd0);
      e.dat = d;
      e.sel = 4'hF;
      e.we  = 1'b1;
      exp_q.push_back(e);
      send_word(d);
      if (i == 0) chk({tag, " stb_latency"}, 32'(wb.stb), 32'd1);
    end
    wait_idle(tag);
    repeat (2) @(negedge clk);
    exp_words = exp_words + 16'(cnt);
    chk({tag, " nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s adr%0d", tag, i), obs_q[i].adr, exp_q[i].adr);
      chk($sformatf("%s dat%0d", tag, i), obs_q[i].dat, exp_q[i].dat);
      chk($sformatf("%s sel%0d", tag, i), 32'(obs_q[i].sel), 32'(exp_q[i].sel));
      chk($sformatf("%s we%0d", tag, i), 32'(obs_q[i].we), 32'(exp_q[i].we));
    end
    chk({tag, " done_count"}, 32'(done_cnt - done0), 32'd1);
    chk({tag, " words"}, 32'(words_o), 32'(exp_words));
    $display("burst %s hdr=%h writes=%0d words=%0d", tag, hdr, obs_q.size(), words_o);
  endtask

  logic [31:0] hdr;
  logic [31:0] ad0;
  int          d0;
  int          n;
  int          stb_cycles;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    abort = 1'b0;
    clear = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready_o), 32'd0);
    chk("rst cyc", 32'(wb.cyc), 32'd0);
    chk("rst stb", 32'(wb.stb), 32'd0);
    chk("rst sel", 32'(wb.sel), 32'd0);
    chk("rst adr", wb.adr, 32'd0);
    chk("rst dat", wb.dat, 32'd0);
    chk("rst words", 32'(words_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", 32'(in_ready_o), 32'd1);
    chk("post_rst busy", 32'(busy_o), 32'd0);

    // Directed bursts
    run_burst("fixed2", 32'h0002_0000, 1, 1'b1);
    run_burst("inc3", 32'h8003_0010, 1, 1'b0);
    run_burst("count0", 32'h0000_0040, 0, 1'b0);
    run_burst("unaligned", 32'h8002_0013, 2, 1'b0);

    // Randomized bursts
    for (int r = 0; r < 6; r++) begin
      hdr = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 4)), 16'($urandom)};
      run_burst($sformatf("rand%0d", r), hdr, $urandom_range(0, 2), 1'b0);
    end

    // Timeout: no ack, strobe held for exactly TIMEOUT cycles
    ack_en = 1'b0;
    obs_q.delete();
    d0 = done_cnt;
    send_word(32'h0001_0200);
    send_word(32'hDEAD_BEEF);
    stb_cycles = 0;
    n = 0;
    while (err_o !== 1'b1 && n < 20) begin
      if (wb.stb === 1'b1) stb_cycles++;
      @(negedge clk);
      n++;
    end
    chk("tmo stb_cycles", 32'(stb_cycles), 32'd4);
    chk("tmo err", 32'(err_o), 32'd1);
    chk("tmo in_ready", 32'(in_ready_o), 32'd0);
    chk("tmo cyc", 32'(wb.cyc), 32'd0);
    chk("tmo busy", 32'(busy_o), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("err abort_ignored err", 32'(err_o), 32'd1);
    chk("err abort_ignored busy", 32'(busy_o), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear err", 32'(err_o), 32'd0);
    chk("clear busy", 32'(busy_o), 32'd0);
    chk("clear in_ready", 32'(in_ready_o), 32'd1);
    chk("tmo words", 32'(words_o), 32'(exp_words));
    chk("tmo no_done", 32'(done_cnt - d0), 32'd0);
    chk("tmo no_writes", 32'(obs_q.size()), 32'd0);
    $display("burst timeout stb_cycles=%0d err=%0d", stb_cycles, err_o);

    // Abort during the second of three writes
    ack_en = 1'b1;
    ack_dly = 1;
    obs_q.delete();
    d0 = done_cnt;
    ad0 = $urandom;
    send_word(32'h8003_0100);
    send_word(ad0);
    send_word($urandom);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_words = exp_words + 16'd1;
    chk("abort cyc", 32'(wb.cyc), 32'd0);
    chk("abort busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort words", 32'(words_o), 32'(exp_words));
    chk("abort nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      chk("abort adr0", obs_q[0].adr, 32'h3000_0100);
      chk("abort dat0", obs_q[0].dat, ad0);
    end
    $display("burst abort writes=%0d words=%0d", obs_q.size(), words_o);

    // Abort coinciding with the final ack: ack counted, done suppressed
    ack_dly = 0;
    obs_q.delete();
    d0 = done_cnt;
    send_word(32'h8002_0200);
    send_word($urandom);
    send_word($urandom);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_words = exp_words + 16'd2;
    repeat (2) @(negedge clk);
    chk("abort_ack busy", 32'(busy_o), 32'd0);
    chk("abort_ack no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_ack words", 32'(words_o), 32'(exp_words));
    chk("abort_ack nwrites", 32'(obs_q.size()), 32'd2);
    $display("burst abort_ack writes=%0d words=%0d", obs_q.size(), words_o);

    // Reset asserted mid-request
    ack_en = 1'b0;
    send_word(32'h0002_0000);
    send_word(32'h1234_5678);
    chk("midrst stb_before", 32'(wb.stb), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst cyc", 32'(wb.cyc), 32'd0);
    chk("midrst stb", 32'(wb.stb), 32'd0);
    chk("midrst words", 32'(words_o), 32'd0);
    chk("midrst in_ready", 32'(in_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_words = 16'd0;
    @(negedge clk);
    chk("midrst release in_ready", 32'(in_ready_o), 32'd1);
    chk("midrst release busy", 32'(busy_o), 32'd0);
    $display("burst midreset words=%0d", words_o);

    run_burst("post_reset", 32'h8001_0008, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
